// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle sequencer and its datapath/memories.
// The sequencer side uses the master modport; the datapath side uses slave.
interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        trap;
  logic [31:0] retired;

  modport master (
    input  opcode, br_taken, imem_ack, dmem_ack,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
           alu_src_b, alu_op, pc_we, pc_src, trap, retired
  );

  modport slave (
    output opcode, br_taken, imem_ack, dmem_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
           alu_src_b, alu_op, pc_we, pc_src, trap, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-style instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory-wait timeout into a sticky TRAP state and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [3:0] C_ILL   = 4'd0;
  localparam logic [3:0] C_R     = 4'd1;
  localparam logic [3:0] C_I     = 4'd2;
  localparam logic [3:0] C_LOAD  = 4'd3;
  localparam logic [3:0] C_STORE = 4'd4;
  localparam logic [3:0] C_BR    = 4'd5;
  localparam logic [3:0] C_JAL   = 4'd6;
  localparam logic [3:0] C_JALR  = 4'd7;
  localparam logic [3:0] C_LUI   = 4'd8;
  localparam logic [3:0] C_AUIPC = 4'd9;

  function automatic logic [3:0] f_classify(input logic [6:0] op);
    case (op)
      7'b0110011: f_classify = C_R;
      7'b0010011: f_classify = C_I;
      7'b0000011: f_classify = C_LOAD;
      7'b0100011: f_classify = C_STORE;
      7'b1100011: f_classify = C_BR;
      7'b1101111: f_classify = C_JAL;
      7'b1100111: f_classify = C_JALR;
      7'b0110111: f_classify = C_LUI;
      7'b0010111: f_classify = C_AUIPC;
      default:    f_classify = C_ILL;
    endcase
  endfunction

  logic [2:0]    r_state;
  logic [3:0]    r_cls;
  logic [WW-1:0] r_wait;
  logic [31:0]   r_retired;

  logic [2:0]    w_next;
  logic [WW-1:0] w_wait_next;
  logic [3:0]    w_dec_cls;
  logic          w_imem_req, w_ir_we, w_dmem_req, w_dmem_we, w_rf_we;
  logic          w_alu_src_b, w_pc_we, w_trap;
  logic [1:0]    w_wb_sel, w_alu_op, w_pc_src;

  assign w_dec_cls = f_classify(bus.opcode);

  always_comb begin
    w_next      = r_state;
    w_wait_next = '0;
    w_imem_req  = 1'b0;
    w_ir_we     = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_rf_we     = 1'b0;
    w_wb_sel    = 2'b00;
    w_alu_src_b = 1'b0;
    w_alu_op    = 2'b00;
    w_pc_we     = 1'b0;
    w_pc_src    = 2'b00;
    w_trap      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end else if (r_wait == WAIT_MAX) begin
          w_next = S_TRAP;
        end else begin
          w_wait_next = r_wait + WW'(1);
        end
      end
      S_DECODE: w_next = (w_dec_cls == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        w_alu_src_b = (r_cls == C_I) || (r_cls == C_LOAD) || (r_cls == C_STORE) ||
                      (r_cls == C_LUI) || (r_cls == C_AUIPC) || (r_cls == C_JALR);
        w_alu_op    = ((r_cls == C_R) || (r_cls == C_I)) ? 2'b10 :
                      (r_cls == C_BR) ? 2'b01 : 2'b00;
        if ((r_cls == C_LOAD) || (r_cls == C_STORE)) begin
          w_next = S_MEM;
        end else if (r_cls == C_BR) begin
          w_pc_we  = 1'b1;
          w_pc_src = bus.br_taken ? 2'b01 : 2'b00;
          w_next   = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_cls == C_STORE);
        if (bus.dmem_ack) begin
          if (r_cls == C_STORE) begin
            w_pc_we = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (r_wait == WAIT_MAX) begin
          w_next = S_TRAP;
        end else begin
          w_wait_next = r_wait + WW'(1);
        end
      end
      S_WB: begin
        w_rf_we  = 1'b1;
        w_pc_we  = 1'b1;
        w_wb_sel = (r_cls == C_LOAD) ? 2'b01 :
                   ((r_cls == C_JAL) || (r_cls == C_JALR)) ? 2'b10 : 2'b00;
        w_pc_src = (r_cls == C_JAL) ? 2'b01 : (r_cls == C_JALR) ? 2'b10 : 2'b00;
        w_next   = S_FETCH;
      end
      S_TRAP:  w_trap = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_cls     <= C_ILL;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (r_state == S_DECODE) r_cls <= w_dec_cls;
      // Counter only advances on PC-update cycles so it simply wraps at 2^32.
      if (w_pc_we) r_retired <= r_retired + 32'd1;
    end
  end

  assign bus.imem_req  = w_imem_req;
  assign bus.ir_we     = w_ir_we;
  assign bus.dmem_req  = w_dmem_req;
  assign bus.dmem_we   = w_dmem_we;
  assign bus.rf_we     = w_rf_we;
  assign bus.wb_sel    = w_wb_sel;
  assign bus.alu_src_b = w_alu_src_b;
  assign bus.alu_op    = w_alu_op;
  assign bus.pc_we     = w_pc_we;
  assign bus.pc_src    = w_pc_src;
  assign bus.trap      = w_trap;
  assign bus.retired   = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded from its
// class into an expected per-cycle output list and compared cycle by cycle.
module tb_multicycle_ctrl;
  localparam int TIMEOUT = 15;

  typedef enum int {K_ILL, K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC} ic_t;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       trap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] m_ret = '0;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h want=%h", tag, $time, got, exp);
    end
  endtask

  function automatic ic_t cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // One clock: drive inputs, sample at the falling edge, advance past the rising edge.
  task automatic step(input logic ia, input logic da, input logic br,
                      input logic [6:0] op, input logic r, input exp_t e);
    logic [13:0] got;
    bus.imem_ack = ia;
    bus.dmem_ack = da;
    bus.br_taken = br;
    bus.opcode   = op;
    rst          = r;
    @(negedge clk);
    got = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.wb_sel,
           bus.alu_src_b, bus.alu_op, bus.pc_we, bus.pc_src, bus.trap};
    chk("outs", 32'(got), 32'(e));
    chk("retired", bus.retired, m_ret);
    if (e.pc_we && !r) m_ret = m_ret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic trap_and_reset();
    exp_t e;
    e = '0;
    e.trap = 1'b1;
    repeat (20) step(rb(), rb(), rb(), rop(), 1'b0, e);
    step(rb(), rb(), rb(), rop(), 1'b1, e);
    m_ret = '0;
  endtask

  // idly/ddly: number of no-ack cycles before the ack; rst_mem: MEM wait cycle to reset in (-1 none).
  task automatic do_instr(input logic [6:0] op, input logic br, input int idly,
                          input int ddly, input int rst_mem);
    ic_t  c;
    exp_t e;
    c = cls_of(op);
    e = '0;
    e.imem_req = 1'b1;
    for (int i = 0; i < idly && i <= TIMEOUT; i++) step(1'b0, rb(), rb(), rop(), 1'b0, e);
    if (idly > TIMEOUT) begin
      trap_and_reset();
      return;
    end
    e.ir_we = 1'b1;
    step(1'b1, rb(), rb(), rop(), 1'b0, e);
    e = '0;
    step(rb(), rb(), rb(), op, 1'b0, e);
    if (c == K_ILL) begin
      trap_and_reset();
      return;
    end
    e.alu_src_b = c inside {K_I, K_LD, K_ST, K_LUI, K_AUIPC, K_JALR};
    e.alu_op    = (c == K_R || c == K_I) ? 2'b10 : (c == K_BR) ? 2'b01 : 2'b00;
    if (c == K_BR) begin
      e.pc_we  = 1'b1;
      e.pc_src = br ? 2'b01 : 2'b00;
    end
    step(rb(), rb(), br, rop(), 1'b0, e);
    if (c == K_BR) return;
    if (c == K_LD || c == K_ST) begin
      e = '0;
      e.dmem_req = 1'b1;
      e.dmem_we  = (c == K_ST);
      for (int i = 0; i < ddly && i <= TIMEOUT; i++) begin
        if (i == rst_mem) begin
          step(rb(), 1'b0, rb(), rop(), 1'b1, e);
          m_ret = '0;
          return;
        end
        step(rb(), 1'b0, rb(), rop(), 1'b0, e);
      end
      if (ddly > TIMEOUT) begin
        trap_and_reset();
        return;
      end
      e.pc_we = (c == K_ST);
      step(rb(), 1'b1, rb(), rop(), 1'b0, e);
      if (c == K_ST) return;
    end
    e = '0;
    e.rf_we  = 1'b1;
    e.pc_we  = 1'b1;
    e.wb_sel = (c == K_LD) ? 2'b01 : (c == K_JAL || c == K_JALR) ? 2'b10 : 2'b00;
    e.pc_src = (c == K_JAL) ? 2'b01 : (c == K_JALR) ? 2'b10 : 2'b00;
    step(rb(), rb(), rb(), rop(), 1'b0, e);
  endtask

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

  initial begin
    exp_t idle;
    logic [6:0] op;
    int idly, ddly;
    idle = '0;
    idle.imem_req = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.br_taken = 1'b0;
    bus.opcode   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_ret = '0;

    do_instr(7'b0110011, 1'b0, 0, 0, -1);    // add, zero wait
    do_instr(7'b0000011, 1'b0, 0, 3, -1);    // lw, dmem 3 late
    do_instr(7'b1100011, 1'b1, 0, 0, -1);    // beq taken
    do_instr(7'b1100011, 1'b0, 1, 0, -1);    // beq not taken
    do_instr(7'b1100111, 1'b0, 0, 0, -1);    // jalr
    do_instr(7'b1101111, 1'b0, 2, 0, -1);    // jal
    do_instr(7'b0100011, 1'b0, 0, 2, -1);    // sw
    do_instr(7'b1111111, 1'b0, 0, 0, -1);    // illegal -> trap
    do_instr(7'b0000000, 1'b0, 0, 0, -1);    // illegal -> trap
    do_instr(7'b0010011, 1'b0, TIMEOUT, 0, -1);       // ack on the limit cycle
    do_instr(7'b0110011, 1'b0, TIMEOUT + 1, 0, -1);   // fetch timeout
    do_instr(7'b0100011, 1'b0, 0, TIMEOUT, -1);       // dmem ack on the limit
    do_instr(7'b0000011, 1'b0, 0, TIMEOUT + 1, -1);   // dmem timeout
    do_instr(7'b0000011, 1'b0, 0, 5, 2);              // reset mid-MEM
    step(1'b0, rb(), rb(), rop(), 1'b0, idle);

    m_ret = 32'hFFFF_FFFF;
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    do_instr(7'b0110011, 1'b0, 0, 0, -1);    // wraps to 0
    step(1'b0, rb(), rb(), rop(), 1'b0, idle);

    for (int n = 0; n < 120; n++) begin
      op = ($urandom_range(0, 7) == 0) ? rop() : legal_ops[$urandom_range(0, 8)];
      idly = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 1))
                                          : int'($urandom_range(0, 3));
      ddly = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 1))
                                          : int'($urandom_range(0, 4));
      do_instr(op, rb(), idly, ddly, -1);
    end
    step(1'b0, rb(), rb(), rop(), 1'b0, idle);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for imem_ack/dmem_ack before trapping.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port opcode, input, 7: decoder opcode field, sampled in DECODE.
REQ-005 SHALL have port br_taken, input, 1: ALU compare result, sampled in EXEC.
REQ-006 SHALL have port imem_ack, input, 1: instruction memory data valid.
REQ-007 SHALL have port dmem_ack, input, 1: data memory access complete.
REQ-008 SHALL have port imem_req, output, 1: fetch request.
REQ-009 SHALL have port ir_we, output, 1: instruction register load strobe.
REQ-010 SHALL have port dmem_req, output, 1: data memory request.
REQ-011 SHALL have port dmem_we, output, 1: data memory write (store).
REQ-012 SHALL have port rf_we, output, 1: register file write strobe.
REQ-013 SHALL have port wb_sel, output, 2: writeback mux select (00 ALU, 01 MEM, 10 PC+4).
REQ-014 SHALL have port alu_src_b, output, 1: ALU B operand select (1 = immediate).
REQ-015 SHALL have port alu_op, output, 2: ALU mode (00 add, 01 branch compare, 10 fn3/fn7 driven).
REQ-016 SHALL have port pc_we, output, 1: PC update strobe.
REQ-017 SHALL have port pc_src, output, 2: next-PC select (00 PC+4, 01 branch/JAL target, 10 JALR target).
REQ-018 SHALL have port trap, output, 1: sticky error flag.
REQ-019 SHALL have port retired, output, 32: retired instruction count.

Function
REQ-020 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP in a registered state variable.
REQ-021 SHALL classify opcode in DECODE into a registered class: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; any other value (including 0000000 and 1111111) illegal.
REQ-022 FETCH: imem_req=1; on imem_ack, ir_we=1 in that same cycle and next state DECODE; otherwise remain in FETCH.
REQ-023 DECODE: one cycle, no strobes; illegal class -> TRAP, else -> EXEC.
REQ-024 EXEC: one cycle; alu_src_b=1 for I/LOAD/STORE/LUI/AUIPC/JALR; alu_op=10 for R/I, 01 for BRANCH, 00 otherwise.
REQ-025 EXEC transitions: LOAD/STORE -> MEM; BRANCH -> FETCH with pc_we=1, pc_src=01 if br_taken else 00; all other classes -> WB.
REQ-026 MEM: dmem_req=1, dmem_we=1 only for STORE; on dmem_ack, LOAD -> WB, STORE -> FETCH with pc_we=1, pc_src=00.
REQ-027 WB: rf_we=1, pc_we=1; wb_sel=01 for LOAD, 10 for JAL/JALR, 00 otherwise; pc_src=01 for JAL, 10 for JALR, 00 otherwise; next state FETCH.
REQ-028 SHALL increment retired by 1 on every cycle with pc_we=1; wraps from 0xFFFFFFFF to 0.
REQ-029 SHALL count consecutive wait cycles in FETCH and MEM; counter clears on ack or state exit; reaching TIMEOUT without ack -> TRAP.
REQ-030 An ack arriving in the cycle the wait counter reaches TIMEOUT SHALL be honoured (no trap).
REQ-031 TRAP: trap=1, all strobes and requests 0, retired frozen; exits only via rst.
REQ-032 All outputs not explicitly asserted in a state SHALL be 0; ack inputs outside FETCH/MEM SHALL be ignored.
REQ-033 Zero-wait latency: R/I/LUI/AUIPC/JAL/JALR and STORE 4 cycles, LOAD 5, BRANCH 3.

Reset
REQ-034 rst=1 SHALL force state FETCH, retired=0, trap=0, wait counter 0, class register 0, all strobes 0 on the next edge, overriding any in-flight transition.
REQ-035 rst asserted mid-MEM SHALL abandon the access; dmem_req=0 from the cycle after the reset edge.
REQ-036 First cycle after rst deasserts SHALL assert imem_req=1.

Verification
REQ-037 add (0110011), acks immediate -> ir_we cycle 1, rf_we+pc_we cycle 4, wb_sel=00, pc_src=00, retired=1.
REQ-038 lw (0000011), dmem_ack 3 cycles late -> dmem_req held 4 cycles, dmem_we=0, then WB wb_sel=01, retired increments once.
REQ-039 beq (1100011), br_taken=1 -> pc_we with pc_src=01 in cycle 3, rf_we never 1; br_taken=0 -> pc_src=00.
REQ-040 jalr (1100111) -> WB wb_sel=10, pc_src=10, alu_src_b=1 in EXEC.
REQ-041 opcode 1111111 -> TRAP after DECODE, trap=1, all strobes 0 for 20+ cycles; rst -> imem_req=1, trap=0.
REQ-042 imem_ack never asserted -> TRAP after TIMEOUT=15 wait cycles; retired preset 0xFFFFFFFF then one add -> retired=0.
